// File: rtl/bank_arb_pkg.sv
// Purpose: shared state encoding, router select codes and host op codes for the bank arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bank_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_EXT_RD   = 3'd1,
        ST_EXT_WR   = 3'd2,
        ST_EXT_CLR  = 3'd3,
        ST_SEQ_RD   = 3'd4,
        ST_SEQ_WAIT = 3'd5
    } state_t;

    // Router data-source select
    localparam logic [1:0] SEL_DATA_IN = 2'd0;
    localparam logic [1:0] SEL_RESULT  = 2'd1;
    localparam logic [1:0] SEL_ZERO    = 2'd2;

    // Router write-enable select
    localparam logic [1:0] WR_REQ      = 2'd0;   // WRITE_REQ
    localparam logic [1:0] WR_REQ_RDY  = 2'd1;   // WRITE_REQ & READY
    localparam logic [1:0] WR_NEVER    = 2'd2;
    localparam logic [1:0] WR_ALWAYS   = 2'd3;

    // Router address-direction select
    localparam logic DIR_EXT = 1'b1;
    localparam logic DIR_CTL = 1'b0;

    // Host operation codes; code 3 is reserved and behaves as a read
    localparam logic [1:0] OP_READ  = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_CLEAR = 2'd2;

    // Write-back wait counter width (TMO is limited to 1..255)
    localparam int TMO_W = 8;

    function automatic state_t ext_op_state(input logic [1:0] op);
        case (op)
            OP_READ:  return ST_EXT_RD;
            OP_WRITE: return ST_EXT_WR;
            OP_CLEAR: return ST_EXT_CLR;
            default:  return ST_EXT_RD;
        endcase
    endfunction

endpackage

// File: rtl/bank_arb_tmo.sv
// Purpose: write-back wait counter; cleared by load, counts while enabled, saturates at TMO.
// Latency: expired is a combinational compare of the registered count.
// Backpressure: none; en is ignored once expired.
// Ports: clk, rst_n (async active-low), load (clear to 0), en (count), expired (count == TMO).
module bank_arb_tmo
    import bank_arb_pkg::*;
#(
    parameter int TMO = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic expired
);

    localparam logic [TMO_W-1:0] LIMIT = TMO_W'(TMO);

    logic [TMO_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= '0;
        end else if (en && !expired) begin
            cnt_q <= cnt_q + TMO_W'(1);
        end
    end

    assign expired = (cnt_q == LIMIT);

endmodule

// File: rtl/bank_arbiter.sv
// Purpose: arbitrates host and sequencer access to the data bank and drives the router selects.
// Latency: grant one edge after request in IDLE; host ops 1 cycle; sequencer write-back waits for READY up to TMO.
// Backpressure: requests are held until ACK/GNT; requests outside IDLE are not sampled.
// Ports: CLK/RST_N; host EXT_REQ/EXT_OP/EXT_ACK; sequencer SEQ_REQ/SEQ_WB/SEQ_GNT/SEQ_DONE;
//        READY (ALU result valid); router sel_data/sel_dira/sel_dirb/sel_write/WRITE_REQ; BUSY, ERR (sticky timeout).
module bank_arbiter
    import bank_arb_pkg::*;
#(
    parameter int ADDRW = 5,
    parameter int TMO   = 255
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       EXT_REQ,
    input  logic [1:0] EXT_OP,
    output logic       EXT_ACK,
    input  logic       SEQ_REQ,
    input  logic       SEQ_WB,
    output logic       SEQ_GNT,
    output logic       SEQ_DONE,
    input  logic       READY,
    output logic [1:0] sel_data,
    output logic       sel_dira,
    output logic       sel_dirb,
    output logic [1:0] sel_write,
    output logic       WRITE_REQ,
    output logic       BUSY,
    output logic       ERR
);

    if (ADDRW < 1 || TMO < 1 || TMO > 255) begin : g_param_check
        $error("bank_arbiter: ADDRW must be >= 1 and TMO in 1..255");
    end

    state_t state_q, state_d;
    logic   rr_seq_q;      // set: sequencer wins the next tie
    logic   err_q;
    logic   grant_ext, grant_seq;
    logic   tmo_expired;

    // Next state and grant decisions
    always_comb begin
        state_d   = state_q;
        grant_ext = 1'b0;
        grant_seq = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (EXT_REQ && (!SEQ_REQ || !rr_seq_q)) begin
                    grant_ext = 1'b1;
                    state_d   = ext_op_state(EXT_OP);
                end else if (SEQ_REQ) begin
                    grant_seq = 1'b1;
                    state_d   = ST_SEQ_RD;
                end
            end
            ST_EXT_RD, ST_EXT_WR, ST_EXT_CLR: state_d = ST_IDLE;
            ST_SEQ_RD:   state_d = SEQ_WB ? ST_SEQ_WAIT : ST_IDLE;
            ST_SEQ_WAIT: if (READY || tmo_expired) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // Router selects are pure state decodes; the handshake pulses may look at SEQ_WB/READY
    always_comb begin
        sel_data  = SEL_ZERO;
        sel_dira  = DIR_CTL;
        sel_dirb  = DIR_CTL;
        sel_write = WR_NEVER;
        WRITE_REQ = 1'b0;
        EXT_ACK   = 1'b0;
        SEQ_GNT   = 1'b0;
        SEQ_DONE  = 1'b0;
        case (state_q)
            ST_EXT_RD: begin
                sel_dira = DIR_EXT;
                sel_dirb = DIR_EXT;
                EXT_ACK  = 1'b1;
            end
            ST_EXT_WR: begin
                sel_data  = SEL_DATA_IN;
                sel_dira  = DIR_EXT;
                sel_dirb  = DIR_EXT;
                sel_write = WR_REQ;
                WRITE_REQ = 1'b1;
                EXT_ACK   = 1'b1;
            end
            ST_EXT_CLR: begin
                sel_dira  = DIR_EXT;
                sel_dirb  = DIR_EXT;
                sel_write = WR_ALWAYS;
                EXT_ACK   = 1'b1;
            end
            ST_SEQ_RD: begin
                SEQ_GNT  = 1'b1;
                SEQ_DONE = !SEQ_WB;
            end
            ST_SEQ_WAIT: begin
                // The write is gated by READY in the router, so a timeout exit writes nothing
                sel_data  = SEL_RESULT;
                sel_write = WR_REQ_RDY;
                WRITE_REQ = 1'b1;
                SEQ_DONE  = READY || tmo_expired;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= ST_IDLE;
            rr_seq_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (grant_ext) begin
                rr_seq_q <= 1'b1;
            end else if (grant_seq) begin
                rr_seq_q <= 1'b0;
            end
            if (state_q == ST_SEQ_WAIT && tmo_expired && !READY) begin
                err_q <= 1'b1;
            end
        end
    end

    // Count is cleared during the operand read so the first wait cycle sees 0
    bank_arb_tmo #(.TMO(TMO)) u_tmo (
        .clk     (CLK),
        .rst_n   (RST_N),
        .load    (state_q == ST_SEQ_RD),
        .en      (state_q == ST_SEQ_WAIT),
        .expired (tmo_expired)
    );

    assign BUSY = (state_q != ST_IDLE);
    assign ERR  = err_q;

endmodule

// File: tb/tb_bank_arbiter.sv
module tb_bank_arbiter;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic       EXT_REQ, SEQ_REQ, SEQ_WB, READY;
    logic [1:0] EXT_OP;
    logic       EXT_ACK, SEQ_GNT, SEQ_DONE;
    logic [1:0] sel_data, sel_write;
    logic       sel_dira, sel_dirb, WRITE_REQ, BUSY, ERR;

    bank_arbiter #(.ADDRW(5), .TMO(4)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .EXT_REQ(EXT_REQ), .EXT_OP(EXT_OP), .EXT_ACK(EXT_ACK),
        .SEQ_REQ(SEQ_REQ), .SEQ_WB(SEQ_WB), .SEQ_GNT(SEQ_GNT), .SEQ_DONE(SEQ_DONE),
        .READY(READY),
        .sel_data(sel_data), .sel_dira(sel_dira), .sel_dirb(sel_dirb),
        .sel_write(sel_write), .WRITE_REQ(WRITE_REQ),
        .BUSY(BUSY), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    // Expected transaction as seen from the bank: who is granted, what it does, how long it waits
    typedef struct {
        bit is_seq;
        int op;
        bit wb;
        int waits;   // cycles spent waiting for READY (5 for TMO=4 timeout)
        bit tmo;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model state
    bit   rr_ext = 1'b1;    // host wins the next tie
    bit   err_exp = 1'b0;

    // Monitor state
    bit   mon_en = 1'b0;
    bit   post_chk = 1'b0;
    bit   in_wait = 1'b0;
    int   wait_cnt = 0;
    exp_t cur;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: event did not occur within bound at %0t", nm, $time);
    endtask

    function automatic void push_ext(input int op);
        exp_t e;
        e.is_seq = 1'b0; e.op = op; e.wb = 1'b0; e.waits = 0; e.tmo = 1'b0;
        sb.push_back(e);
        rr_ext = 1'b0;
    endfunction

    function automatic void push_seq(input bit wb, input int d);
        exp_t e;
        e.is_seq = 1'b1; e.op = 0; e.wb = wb;
        e.waits = (d < 0) ? 5 : d;
        e.tmo = (d < 0);
        sb.push_back(e);
        rr_ext = 1'b1;
    endfunction

    // which: 0 EXT_ACK, 1 SEQ_GNT, 2 SEQ_DONE
    task automatic wait_for(input int which, input string nm);
        bit seen = 1'b0;
        for (int n = 0; n < 30 && !seen; n++) begin
            @(negedge CLK);
            case (which)
                0: seen = EXT_ACK;
                1: seen = SEQ_GNT;
                default: seen = SEQ_DONE;
            endcase
        end
        if (!seen) timeout_fail(nm);
    endtask

    task automatic ext_txn(input int op);
        @(posedge CLK); #1;
        push_ext(op);
        EXT_OP = 2'(op);
        EXT_REQ = 1'b1;
        wait_for(0, "ext_ack_wait");
        EXT_REQ = 1'b0;
    endtask

    // d: READY asserted in wait cycle d (1..5); d < 0 keeps READY low
    task automatic seq_txn(input bit wb, input int d);
        @(posedge CLK); #1;
        push_seq(wb, d);
        SEQ_WB = wb;
        READY = 1'b0;
        SEQ_REQ = 1'b1;
        wait_for(1, "seq_gnt_wait");
        SEQ_REQ = 1'b0;
        if (wb) begin
            if (d > 0) begin
                repeat (d) begin @(posedge CLK); #1; end
                READY = 1'b1;
            end
            wait_for(2, "seq_done_wait");
            @(posedge CLK); #1;
            READY = 1'b0;
        end
    endtask

    task automatic contend();
        int op;
        @(posedge CLK); #1;
        op = $urandom_range(0, 3);
        if (rr_ext) begin push_ext(op); push_seq(1'b0, 0); end
        else begin push_seq(1'b0, 0); push_ext(op); end
        EXT_OP = 2'(op);
        SEQ_WB = 1'b0;
        EXT_REQ = 1'b1;
        SEQ_REQ = 1'b1;
        for (int n = 0; n < 30 && (EXT_REQ || SEQ_REQ); n++) begin
            @(negedge CLK);
            if (EXT_ACK) EXT_REQ = 1'b0;
            if (SEQ_GNT) SEQ_REQ = 1'b0;
        end
        if (EXT_REQ || SEQ_REQ) begin
            timeout_fail("contend_grants");
            EXT_REQ = 1'b0;
            SEQ_REQ = 1'b0;
        end
    endtask

    // Scoreboard monitor
    always @(negedge CLK) begin
        if (mon_en) begin
            if (post_chk) begin
                post_chk = 1'b0;
                chk("idle_busy", BUSY, 0);
                chk("idle_sel_data", sel_data, 2);
                chk("idle_sel_write", sel_write, 2);
                chk("idle_write_req", WRITE_REQ, 0);
                chk("idle_dir", {sel_dira, sel_dirb}, 0);
                chk("err_flag", ERR, err_exp);
            end else if (in_wait) begin
                wait_cnt++;
                chk("wait_busy", BUSY, 1);
                chk("wait_sel_data", sel_data, 1);
                chk("wait_sel_write", sel_write, 1);
                chk("wait_write_req", WRITE_REQ, 1);
                chk("wait_dira", sel_dira, 0);
                if (SEQ_DONE) begin
                    chk("wait_cycles", wait_cnt, cur.waits);
                    chk("done_with_ready", READY, !cur.tmo);
                    if (cur.tmo) err_exp = 1'b1;
                    in_wait = 1'b0;
                    post_chk = 1'b1;
                end else if (wait_cnt > 8) begin
                    timeout_fail("seq_wait_stuck");
                    in_wait = 1'b0;
                end
            end else if (EXT_ACK || SEQ_GNT) begin
                chk("ack_gnt_exclusive", EXT_ACK & SEQ_GNT, 0);
                chk("grant_busy", BUSY, 1);
                if (sb.size() == 0) begin
                    timeout_fail("unexpected_grant");
                end else begin
                    cur = sb.pop_front();
                    chk("grant_kind", SEQ_GNT, cur.is_seq);
                    if (EXT_ACK) begin
                        chk("ext_seq_done", SEQ_DONE, 0);
                        case (cur.op)
                            1: begin
                                chk("wr_sel_data", sel_data, 0);
                                chk("wr_dira", sel_dira, 1);
                                chk("wr_sel_write", sel_write, 0);
                                chk("wr_write_req", WRITE_REQ, 1);
                            end
                            2: begin
                                chk("clr_sel_data", sel_data, 2);
                                chk("clr_dira", sel_dira, 1);
                                chk("clr_sel_write", sel_write, 3);
                            end
                            default: begin
                                chk("rd_dir", {sel_dira, sel_dirb}, 3);
                                chk("rd_sel_write", sel_write, 2);
                            end
                        endcase
                        post_chk = 1'b1;
                    end else begin
                        chk("seqrd_dir", {sel_dira, sel_dirb}, 0);
                        chk("seqrd_sel_write", sel_write, 2);
                        chk("seqrd_done", SEQ_DONE, !cur.wb);
                        if (cur.wb) begin
                            in_wait = 1'b1;
                            wait_cnt = 0;
                        end else begin
                            post_chk = 1'b1;
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        RST_N = 1'b0;
        EXT_REQ = 1'b0; EXT_OP = 2'd0;
        SEQ_REQ = 1'b0; SEQ_WB = 1'b0; READY = 1'b0;
        #1;
        chk("rst_busy", BUSY, 0);
        chk("rst_sel_data", sel_data, 2);
        chk("rst_sel_write", sel_write, 2);
        chk("rst_dir", {sel_dira, sel_dirb}, 0);
        chk("rst_write_req", WRITE_REQ, 0);
        chk("rst_pulses", {EXT_ACK, SEQ_GNT, SEQ_DONE}, 0);
        chk("rst_err", ERR, 0);
        repeat (2) @(posedge CLK);
        #1 RST_N = 1'b1;
        mon_en = 1'b1;

        // Tie from reset: EXT, SEQ, EXT, SEQ
        contend();
        contend();
        ext_txn(1);
        ext_txn(2);
        seq_txn(1'b1, 3);
        seq_txn(1'b1, 5);     // READY on the last count value still commits
        seq_txn(1'b0, 0);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 4))
                0, 1: ext_txn($urandom_range(0, 3));
                2:    seq_txn(1'b0, 0);
                3:    seq_txn(1'b1, $urandom_range(1, 5));
                default: contend();
            endcase
        end

        seq_txn(1'b1, -1);    // timeout
        ext_txn(0);           // ERR must stay set
        repeat (3) @(negedge CLK);
        chk("sb_empty", sb.size(), 0);
        chk("sticky_err", ERR, 1);

        // Reset in the middle of a write-back wait
        mon_en = 1'b0;
        @(posedge CLK); #1;
        SEQ_WB = 1'b1; READY = 1'b0; SEQ_REQ = 1'b1;
        wait_for(1, "seq_gnt_wait_rst");
        SEQ_REQ = 1'b0;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        chk("pre_rst_write_req", WRITE_REQ, 1);
        RST_N = 1'b0;
        #1;
        chk("midrst_busy", BUSY, 0);
        chk("midrst_sel_data", sel_data, 2);
        chk("midrst_sel_write", sel_write, 2);
        chk("midrst_write_req", WRITE_REQ, 0);
        chk("midrst_pulses", {EXT_ACK, SEQ_GNT, SEQ_DONE}, 0);
        chk("midrst_err", ERR, 0);
        @(posedge CLK); #1;
        RST_N = 1'b1;
        sb.delete();
        rr_ext = 1'b1;
        err_exp = 1'b0;
        in_wait = 1'b0;
        post_chk = 1'b0;
        mon_en = 1'b1;
        contend();            // host must win again after reset
        seq_txn(1'b1, 2);
        ext_txn(3);
        repeat (3) @(negedge CLK);
        chk("sb_empty_end", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bank_arbiter.md
BANK_ARBITER -- requirements
Module: bank_arbiter

Interface
REQ-001 SHALL have parameter ADDRW, default 5: address width, matching the router/data-bank address width.
REQ-002 SHALL have parameter TMO, default 255: maximum number of cycles to wait for READY on a write-back (1..255).
REQ-003 SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port RST_N, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port EXT_REQ, input, 1 bit: host access request, held high until EXT_ACK.
REQ-006 SHALL have port EXT_OP, input, 2 bits: host operation; 0 read, 1 write, 2 clear, 3 reserved (treated as read).
REQ-007 SHALL have port EXT_ACK, output, 1 bit: one-cycle host completion pulse.
REQ-008 SHALL have port SEQ_REQ, input, 1 bit: sequencer operand-fetch request, held high until SEQ_GNT.
REQ-009 SHALL have port SEQ_WB, input, 1 bit: sampled with the grant; 1 means the operation writes RESULT back.
REQ-010 SHALL have port SEQ_GNT, output, 1 bit: one-cycle pulse; operand read at CTL_A/CTL_B occurs this cycle.
REQ-011 SHALL have port SEQ_DONE, output, 1 bit: one-cycle sequencer completion pulse.
REQ-012 SHALL have port READY, input, 1 bit: ALU result valid; also drives the router READY input.
REQ-013 SHALL have output ports sel_data (2 bits), sel_dira (1 bit), sel_dirb (1 bit), sel_write (2 bits) and WRITE_REQ (1 bit): router controls.
REQ-014 SHALL have ports BUSY (output, 1 bit, state is not IDLE) and ERR (output, 1 bit, sticky timeout flag).

Function
REQ-015 SHALL use router encodings: sel_data 0=DATA_IN, 1=RESULT, 2=zero; sel_dir 1=DIR_EXT, 0=CTL; sel_write 0=WRITE_REQ, 1=WRITE_REQ&READY, 2=never, 3=always.
REQ-016 SHALL implement states IDLE, EXT_RD, EXT_WR, EXT_CLR, SEQ_RD, SEQ_WAIT.
REQ-017 SHALL decode all select outputs and WRITE_REQ from the state register only (Moore).
REQ-018 SHALL drive, in IDLE: sel_data=2, sel_dira=0, sel_dirb=0, sel_write=2, WRITE_REQ=0.
REQ-019 SHALL, in IDLE with a single requester, move to that requester's state on the next edge; EXT_OP selects EXT_RD, EXT_WR or EXT_CLR.
REQ-020 SHALL, in IDLE with both requesting, grant the requester not granted last (1-bit round-robin pointer); after reset the pointer favours EXT.
REQ-021 SHALL treat EXT_RD as one cycle: sel_dira=1, sel_dirb=1, sel_write=2, EXT_ACK=1, then return to IDLE.
REQ-022 SHALL treat EXT_WR as one cycle: sel_data=0, sel_dira=1, sel_write=0, WRITE_REQ=1, EXT_ACK=1, then return to IDLE.
REQ-023 SHALL treat EXT_CLR as one cycle: sel_data=2, sel_dira=1, sel_write=3, EXT_ACK=1, then return to IDLE.
REQ-024 SHALL, in SEQ_RD (one cycle): drive sel_dira=0, sel_dirb=0, sel_write=2 and SEQ_GNT=1; go to SEQ_WAIT if SEQ_WB=1, else pulse SEQ_DONE in the same cycle and return to IDLE.
REQ-025 SHALL, in SEQ_WAIT: drive sel_data=1, sel_dira=0, sel_write=1, WRITE_REQ=1 and load a wait counter with 0 on entry.
REQ-026 SHALL, in SEQ_WAIT when READY=1: assert SEQ_DONE combinationally (the write commits that cycle) and return to IDLE.
REQ-027 SHALL, in SEQ_WAIT when the counter reaches TMO with READY=0: set ERR, pulse SEQ_DONE, and return to IDLE with no write.
REQ-028 SHALL treat a request deasserted in IDLE before the grant as cancelled.
REQ-029 SHALL ignore requests while not in IDLE; minimum spacing between grants is 2 cycles.
REQ-030 SHALL clear ERR only on reset.

Reset
REQ-031 SHALL, while RST_N=0 (including mid-transaction), immediately force: state IDLE, IDLE select values, EXT_ACK=SEQ_GNT=SEQ_DONE=0, ERR=0, BUSY=0, pointer=EXT-favoured, counter=0.

Structure
REQ-032 SHALL take the state encoding, the sel_data/sel_write codes and the EXT_OP codes from shared package bank_arb_pkg.
REQ-033 SHALL place the wait counter in sub-module bank_arb_tmo (load, enable, expired).

Verification
REQ-034 SHALL test: EXT_REQ=1 with EXT_OP=1 -> 1 cycle later sel_data=0, sel_dira=1, sel_write=0, WRITE_REQ=1, EXT_ACK=1; next cycle IDLE.
REQ-035 SHALL test: EXT_REQ and SEQ_REQ both held, from reset -> grants in the order EXT, SEQ, EXT, SEQ.
REQ-036 SHALL test: SEQ_REQ with SEQ_WB=1 and READY rising 3 cycles after SEQ_GNT -> SEQ_WAIT held 3 cycles, SEQ_DONE coincides with READY, sel_write=1 throughout.
REQ-037 SHALL test: TMO=4 with READY held 0 -> ERR=1 and SEQ_DONE after 5 cycles in SEQ_WAIT, no WRITE_REQ afterwards.
REQ-038 SHALL test: EXT_OP=2 -> sel_data=2, sel_write=3 for 1 cycle.
REQ-039 SHALL test: RST_N low during SEQ_WAIT -> IDLE outputs immediately, ERR=0.
